// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer
//  Purpose  : Responder for the ROB store-commit port. Committed stores are
//             acknowledged one cycle after acceptance into a DEPTH-entry FIFO.
//             The FIFO then drains them in order to the data cache write port.
//             Loads that hit the word of a pending or accepting store are
//             flagged so that the load/store buffer can hold them.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             mem_write/mem_address/mem_wdata/mem_byte_enable -> mem_resp
//                                             ROB store-commit handshake
//             dc_write/dc_address/dc_wdata/dc_byte_enable <- dc_resp
//                                             data cache write handshake
//             dc_rd_busy                      cache busy with a load
//             ld_req/ld_addr -> ld_conflict   load hazard lookup
//             empty, count                    occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_byte_enable,
  output logic             mem_resp,
  output logic             dc_write,
  output logic [31:0]      dc_address,
  output logic [31:0]      dc_wdata,
  output logic [3:0]       dc_byte_enable,
  input  logic             dc_resp,
  input  logic             dc_rd_busy,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  // FIFO storage (no reset needed: validity is tracked by pointers/count)
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             resp_q;
  drain_state_t     state;

  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] entry_hit;
  logic             accept_hit;

  // Load lookups compare whole words; the byte offset is irrelevant.
  logic             unused_ld_lsb;
  assign unused_ld_lsb = &{1'b0, ld_addr[1:0]};

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // resp_q blocks a second accept while the ROB still holds the same store
  // during its mem_resp cycle.
  assign push = mem_write & ~full & ~resp_q;
  assign pop  = (state == WRITE) & dc_resp;

  assign mem_resp = resp_q;

  // --------------------------------------------------------------------------
  // Storage write
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mem_address;
      data_q[wr_ptr] <= mem_wdata;
      be_q[wr_ptr]   <= mem_byte_enable;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and accept response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= push;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM with registered cache outputs. The head entry cannot be
  // overwritten while in WRITE (the FIFO is non-empty, so wr_ptr only
  // equals rd_ptr when full, which blocks the push), so the outputs stay
  // stable until dc_resp. Returning to IDLE on every completion guarantees
  // an idle cycle between cache writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dc_write       <= 1'b0;
      dc_address     <= '0;
      dc_wdata       <= '0;
      dc_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && !dc_rd_busy) begin
            state          <= WRITE;
            dc_write       <= 1'b1;
            dc_address     <= addr_q[rd_ptr];
            dc_wdata       <= data_q[rd_ptr];
            dc_byte_enable <= be_q[rd_ptr];
          end
        end
        WRITE: begin
          if (dc_resp) begin
            state          <= IDLE;
            dc_write       <= 1'b0;
            dc_address     <= '0;
            dc_wdata       <= '0;
            dc_byte_enable <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          dc_write <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load conflict lookup. An entry is live when its distance from rd_ptr
  // (modulo DEPTH) is below the occupancy; the entry being written to the
  // cache stays live until it is popped.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      logic [PTR_W-1:0] offset;
      logic             live;
      assign offset       = PTR_W'(i) - rd_ptr;
      assign live         = ((PTR_W+1)'(offset) < count_q);
      assign entry_hit[i] = live & (addr_q[i][31:2] == ld_addr[31:2]) & (|be_q[i]);
    end
  endgenerate

  assign accept_hit  = push & (mem_address[31:2] == ld_addr[31:2]) & (|mem_byte_enable);
  assign ld_conflict = ld_req & ((|entry_hit) | accept_hit);

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_store_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    mem_write |-> (mem_address[1:0] == 2'b00))
    else $error("store_write_buffer: misaligned store address");

  a_store_held : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_write && !mem_resp) |=> mem_write)
    else $error("store_write_buffer: mem_write dropped before mem_resp");

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= (PTR_W+1)'(DEPTH))
    else $error("store_write_buffer: occupancy above DEPTH");
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_write_buffer
//  Purpose  : Self-checking bench for store_write_buffer. Accepted stores are
//             pushed to an expected queue; a cache model compares every WRITE
//             cycle against the queue head and pops it when it responds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             mem_write;
  logic [31:0]      mem_address;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_byte_enable;
  logic             mem_resp;
  logic             dc_write;
  logic [31:0]      dc_address;
  logic [31:0]      dc_wdata;
  logic [3:0]       dc_byte_enable;
  logic             dc_resp;
  logic             dc_rd_busy;
  logic             ld_req;
  logic [31:0]      ld_addr;
  logic             ld_conflict;
  logic             empty;
  logic [PTR_W:0]   count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  st_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  auto_resp = 1'b0;
  int  resp_lat  = 1;
  int  lat_cnt   = 0;

  store_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .dc_write(dc_write), .dc_address(dc_address), .dc_wdata(dc_wdata),
    .dc_byte_enable(dc_byte_enable), .dc_resp(dc_resp), .dc_rd_busy(dc_rd_busy),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model + scoreboard: runs 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    dc_resp = 1'b0;
    if (rst_n && dc_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dc_unexpected: got addr=%h data=%h be=%b, expected no write",
                 dc_address, dc_wdata, dc_byte_enable);
      end else if ({dc_address, dc_wdata, dc_byte_enable} !== exp_q[0]) begin
        failures++;
        $display("FAIL dc_entry: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                 dc_address, dc_wdata, dc_byte_enable, exp_q[0].a, exp_q[0].d, exp_q[0].be);
      end
      if (auto_resp) begin
        lat_cnt++;
        if (lat_cnt >= resp_lat) begin
          dc_resp = 1'b1;
          lat_cnt = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end else begin
      lat_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one store, hold until mem_resp, drop in the following cycle.
  // Called and returns on a falling edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat);
    mem_write       = 1'b1;
    mem_address     = a;
    mem_wdata       = d;
    mem_byte_enable = be;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < 60);
    checks++;
    if (!mem_resp) begin
      failures++;
      $display("FAIL store_timeout: addr=%h got no mem_resp within %0d cycles, expected a pulse", a, lat);
    end else begin
      exp_q.push_back('{a: a, d: d, be: be});
    end
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!(empty && exp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!empty || count !== '0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got empty=%b count=%0d pending_expected=%0d, expected empty=1 count=0 pending=0",
               tag, empty, count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    dc_resp = 1'b0; dc_rd_busy = 1'b0; ld_req = 1'b0; ld_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_resp, dc_write, dc_address, dc_wdata, dc_byte_enable, ld_conflict, empty, count} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL reset_state: got resp=%b dcw=%b addr=%h empty=%b count=%0d, expected 0,0,0,1,0",
               mem_resp, dc_write, dc_address, empty, count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_store();
    int lat;
    auto_resp = 1'b1; resp_lat = 3;
    do_store(32'h100, 32'hDEADBEEF, 4'b1111, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL single_resp_latency: got %0d cycles, expected 1", lat);
    end
    checks++;
    if (mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL single_resp_pulse: got mem_resp=%b one cycle later, expected 0", mem_resp);
    end
    checks++;
    if (dc_write !== 1'b1 || dc_address !== 32'h100) begin
      failures++;
      $display("FAIL single_dc_rise: got dc_write=%b addr=%h, expected 1 and 00000100", dc_write, dc_address);
    end
    wait_empty("single");
  endtask

  task automatic test_full();
    int lat;
    int n;
    auto_resp = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_store(32'h1000 + 32'(i * 4), 32'hA0000000 + 32'(i), 4'b1111, lat);
    end
    checks++;
    if (count !== 3'(DEPTH)) begin
      failures++;
      $display("FAIL full_count: got %0d, expected %0d", count, DEPTH);
    end
    mem_write = 1'b1; mem_address = 32'h1010; mem_wdata = 32'hA0000004; mem_byte_enable = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0) begin
        failures++;
        $display("FAIL full_blocked: got mem_resp=%b while full, expected 0", mem_resp);
      end
    end
    auto_resp = 1'b1; resp_lat = 1;
    n = 0;
    while (count != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (count !== 3'd3 || mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL full_first_pop: got count=%0d resp=%b, expected 3 and 0", count, mem_resp);
    end
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL full_fifth_accept: got resp=%b count=%0d, expected 1 and 4", mem_resp, count);
    end else begin
      exp_q.push_back('{a: 32'h1010, d: 32'hA0000004, be: 4'b0101});
    end
    @(negedge clk);
    mem_write = 1'b0;
    wait_empty("full");
  endtask

  task automatic test_back_to_back();
    int lat;
    auto_resp = 1'b1; resp_lat = 2;
    do_store(32'h10, 32'h11111111, 4'b0001, lat);
    do_store(32'h20, 32'h22222222, 4'b0011, lat);
    do_store(32'h30, 32'h33333333, 4'b1100, lat);
    wait_empty("b2b");
  endtask

  task automatic test_conflict();
    int lat;
    auto_resp = 1'b0;
    do_store(32'h204, 32'h0000AB00, 4'b0010, lat);
    ld_req = 1'b1; ld_addr = 32'h206; #1;
    checks++;
    if (ld_conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_hit: got %b for 206, expected 1", ld_conflict);
    end
    ld_addr = 32'h208; #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_miss: got %b for 208, expected 0", ld_conflict);
    end
    ld_req = 1'b0; ld_addr = 32'h204; #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_noreq: got %b with ld_req=0, expected 0", ld_conflict);
    end
    auto_resp = 1'b1; resp_lat = 1;
    wait_empty("conflict");
    ld_req = 1'b1; ld_addr = 32'h206; #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_after_pop: got %b, expected 0", ld_conflict);
    end
    @(negedge clk);
    mem_write = 1'b1; mem_address = 32'h300; mem_wdata = 32'h00CC0000; mem_byte_enable = 4'b0100;
    ld_addr = 32'h302; #1;
    checks++;
    if (ld_conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_accepting: got %b in accept cycle, expected 1", ld_conflict);
    end
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b1) begin
      failures++;
      $display("FAIL conflict_store_resp: got %b, expected 1", mem_resp);
    end else begin
      exp_q.push_back('{a: 32'h300, d: 32'h00CC0000, be: 4'b0100});
    end
    @(negedge clk);
    mem_write = 1'b0;
    ld_req = 1'b0;
    wait_empty("conflict2");
  endtask

  task automatic test_rd_busy();
    int lat;
    auto_resp = 1'b0;
    dc_rd_busy = 1'b1;
    do_store(32'h500, 32'h55AA55AA, 4'b1111, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dc_write !== 1'b0) begin
        failures++;
        $display("FAIL busy_hold: got dc_write=%b while busy, expected 0", dc_write);
      end
    end
    dc_rd_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (dc_write !== 1'b1) begin
      failures++;
      $display("FAIL busy_release: got dc_write=%b, expected 1", dc_write);
    end
    dc_rd_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dc_write !== 1'b1) begin
        failures++;
        $display("FAIL busy_no_abort: got dc_write=%b, expected 1", dc_write);
      end
    end
    auto_resp = 1'b1; resp_lat = 1;
    wait_empty("busy");
    dc_rd_busy = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int lat;
    auto_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_store(32'h700 + 32'(i * 4), 32'h70000000 + 32'(i), 4'b1111, lat);
    end
    checks++;
    if (count !== 3'd3 || dc_write !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup: got count=%0d dc_write=%b, expected 3 and 1", count, dc_write);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (dc_write !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clear: got dc_write=%b count=%0d empty=%b, expected 0,0,1",
               dc_write, count, empty);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    auto_resp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      resp_lat = 1 + (i % 3);
      do_store(32'h800 + 32'(i * 4), 32'h01010101 * 32'(i + 1), 4'(1 + i), lat);
    end
    wait_empty("wrap");
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_back_to_back();
    test_conflict();
    test_rd_busy();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
